// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream valid/ready/data,
// downstream valid/ready/data and the occupancy count.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  logic                           in_valid;
  logic [WIDTH-1:0]               in_data;
  logic                           in_ready;
  logic                           out_valid;
  logic [WIDTH-1:0]               out_data;
  logic                           out_ready;
  logic [$clog2(DEPTH+1)-1:0]     count;

  // Chain side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  // Environment side (drives upstream data and downstream ready).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain: DEPTH valid-tagged stages moved by a
// valid/ready handshake. Empty stages soak up bubbles even when the output
// is stalled. Global hold enable, synchronous flush, registered occupancy.
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,   // synchronous, active low
  input  logic              en,
  input  logic              flush,
  pipe_reg_chain_if.slave   bus
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DEPTH-1:0]            r;

  // Ready chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    r = '0;
    r[DEPTH-1] = bus.out_ready | ~v_q[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) r[k] = ~v_q[k] | r[k+1];
  end

  assign bus.in_ready  = en & r[0] & ~flush;
  assign bus.out_valid = en & v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = cnt_q;

  // Next state: shift into every ready stage; flush wipes the chain.
  // Count is taken from the next valid vector so it never lags v_q.
  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    cnt_d = '0;
    if (en) begin
      if (flush) begin
        v_d = '0;
        d_d = {DEPTH{RESET_VAL}};
      end else begin
        if (r[0]) begin
          v_d[0] = bus.in_valid;
          d_d[0] = bus.in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (r[k]) begin
            v_d[k] = v_q[k-1];
            d_d[k] = d_q[k-1];
          end
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) cnt_d = cnt_d + CW'(v_d[k]);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      d_q   <= {DEPTH{RESET_VAL}};
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: DEPTH=2 and DEPTH=3 instances driven with the
// same stimulus, each checked against a queue-of-words model where every
// word carries its current position in the chain.
module tb_pipe_reg_chain;
  localparam logic [31:0] RV2 = 32'h0;
  localparam logic [31:0] RV3 = 32'hA5A5_0000;

  typedef struct { logic [31:0] data; int pos; } item_t;
  typedef item_t iq_t[$];

  logic clk, reset, en, flush;
  int   checks = 0, errors = 0;
  iq_t  q2, q3;
  bit   rv_due = 1'b1;
  bit   saw5   = 1'b0;

  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(2)) if2 ();
  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(3)) if3 ();

  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(RV2)) u2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .bus(if2));
  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV3)) u3 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Words leave from the far end when downstream is ready; every other word
  // then advances one slot if the slot ahead of it is free.
  function automatic iq_t moved(iq_t q, int depth, logic ordy);
    iq_t m;
    m = q;
    if (m.size() > 0 && m[0].pos == depth-1 && ordy) void'(m.pop_front());
    for (int i = 0; i < m.size(); i++) begin
      int lim;
      lim = (i == 0) ? depth-1 : m[i-1].pos - 1;
      if (m[i].pos + 1 <= lim) m[i].pos = m[i].pos + 1;
    end
    return m;
  endfunction

  function automatic bit slot0_free(iq_t q, int depth, logic ordy);
    iq_t m;
    m = moved(q, depth, ordy);
    return (m.size() == 0) || (m[m.size()-1].pos != 0);
  endfunction

  function automatic iq_t next_q(iq_t q, int depth, logic v, logic [31:0] d,
                                 logic ordy, logic e, logic fl, logic rst);
    iq_t m;
    item_t it;
    if (!rst) return m;
    if (!e)   return q;
    if (fl)   return m;
    m = moved(q, depth, ordy);
    if (v && ((m.size() == 0) || (m[m.size()-1].pos != 0))) begin
      it.data = d;
      it.pos  = 0;
      m.push_back(it);
    end
    return m;
  endfunction

  task automatic chk_dut(input string nm, input iq_t q, input int depth, input logic [31:0] rv,
                         input logic e, input logic fl, input logic ordy,
                         input logic ir, input logic ov, input logic [31:0] od, input int cnt);
    logic exp_ov;
    exp_ov = e && q.size() > 0 && q[0].pos == depth-1;
    chk({nm, ".in_ready"},  32'(ir),  32'(e && !fl && slot0_free(q, depth, ordy)));
    chk({nm, ".out_valid"}, 32'(ov),  32'(exp_ov));
    chk({nm, ".count"},     32'(cnt), 32'(q.size()));
    if (exp_ov) chk({nm, ".out_data"}, od, q[0].data);
    if (rv_due) chk({nm, ".rst_data"}, od, rv);
  endtask

  // One clock: drive at negedge, check just after, advance models at posedge.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                      input logic e, input logic fl, input logic rst);
    @(negedge clk);
    if2.in_valid = v; if2.in_data = d; if2.out_ready = ordy;
    if3.in_valid = v; if3.in_data = d; if3.out_ready = ordy;
    en = e; flush = fl; reset = rst;
    #1;
    chk_dut("d2", q2, 2, RV2, e, fl, ordy, if2.in_ready, if2.out_valid, if2.out_data, int'(if2.count));
    chk_dut("d3", q3, 3, RV3, e, fl, ordy, if3.in_ready, if3.out_valid, if3.out_data, int'(if3.count));
    if ((if2.out_valid && if2.out_data == 32'd5) || (if3.out_valid && if3.out_data == 32'd5)) saw5 = 1'b1;
    @(posedge clk);
    q2 = next_q(q2, 2, v, d, ordy, e, fl, rst);
    q3 = next_q(q3, 3, v, d, ordy, e, fl, rst);
    rv_due = !rst || (e && fl);
  endtask

  task automatic st(input logic v, input logic [31:0] d, input logic ordy);
    step(v, d, ordy, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // Bring state out of X before the first comparison.
    reset = 1'b0; en = 1'b1; flush = 1'b0;
    if2.in_valid = 1'b1; if2.in_data = 32'hDEAD_BEEF; if2.out_ready = 1'b1;
    if3.in_valid = 1'b1; if3.in_data = 32'hDEAD_BEEF; if3.out_ready = 1'b1;
    @(posedge clk);

    // Reset held with valid input present; nothing may be captured.
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    st(1'b0, 32'h0, 1'b1);
    st(1'b0, 32'h0, 1'b1);

    // Streaming 1..4 with out_ready high.
    for (int i = 1; i <= 4; i++) st(1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 4; i++)  st(1'b0, 32'h0, 1'b1);

    // Backpressure: fill, stall three cycles, then drain.
    st(1'b1, 32'hA, 1'b0);
    st(1'b1, 32'hB, 1'b0);
    for (int i = 0; i < 3; i++) st(1'b1, 32'hC, 1'b0);
    for (int i = 0; i < 5; i++) st(1'b0, 32'h0, 1'b1);

    // Bubble collapse: A, gap, B against a stalled output.
    st(1'b1, 32'hA, 1'b0);
    st(1'b0, 32'h0, 1'b0);
    st(1'b1, 32'hB, 1'b0);
    st(1'b0, 32'h0, 1'b0);
    st(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) st(1'b0, 32'h0, 1'b1);

    // Flush with a word offered in the same cycle.
    saw5 = 1'b0;
    st(1'b1, 32'h11, 1'b0);
    st(1'b1, 32'h12, 1'b0);
    step(1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) st(1'b0, 32'h0, 1'b1);
    chk("flush_no5", 32'(saw5), 32'h0);

    // Enable hold mid-stream, with a flush pulse that must be ignored.
    st(1'b1, 32'h21, 1'b1);
    st(1'b1, 32'h22, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h30 + 32'(i), 1'b1, 1'b0, (i == 2), 1'b1);
    st(1'b1, 32'h23, 1'b1);
    for (int i = 0; i < 4; i++) st(1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 63) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
